// File: rtl/sipo_fifo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word holding register.
// A completed word goes to the holding register, or is dropped and flagged as overrun.
module sipo_fifo_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     left,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     word_ready,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  output logic [WIDTH-1:0]         register,
  output logic [$clog2(WIDTH):0]   bit_count,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] register_q, register_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;
  logic             order_q, order_d;
  logic             accept, complete;
  logic [WIDTH-1:0] shifted;

  // NOTE: every signal written here is given a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    accept   = din_valid & ~start;
    complete = accept && (bit_count_q == LAST);

    // The first bit of a frame uses the live pin and latches it for the rest of the frame.
    order_d = order_q;
    if (accept && bit_count_q == '0) order_d = left;

    shifted = order_d ? {register_q[WIDTH-2:0], din} : {din, register_q[WIDTH-1:1]};

    state_d      = state_q;
    register_d   = register_q;
    bit_count_d  = bit_count_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE:    if (accept && !complete) state_d = RECV;
      RECV:    if (start || complete)   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start) begin
      register_d  = '0;
      bit_count_d = '0;
      overrun_d   = 1'b0;
    end else if (accept) begin
      register_d  = shifted;
      bit_count_d = complete ? '0 : bit_count_q + CW'(1);
    end

    if (complete) begin
      if (!word_valid_q || word_ready) begin
        word_d       = shifted;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      register_q   <= '0;
      bit_count_q  <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      order_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      register_q   <= register_d;
      bit_count_q  <= bit_count_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      order_q      <= order_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign register   = register_q;
  assign bit_count  = bit_count_q;
  assign busy       = (state_q == RECV);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_fifo_deserializer.sv
// Self-checking bench for sipo_fifo_deserializer: vector table, directed corner cases,
// and random traffic against a frame-level reference model.
module tb_sipo_fifo_deserializer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, left, din, din_valid, word_ready;
  logic [W-1:0]  word, register;
  logic          word_valid, busy, overrun;
  logic [$clog2(W):0] bit_count;

  int total = 0;
  int bad   = 0;

  sipo_fifo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .left(left), .din(din),
    .din_valid(din_valid), .word_ready(word_ready), .word(word),
    .word_valid(word_valid), .register(register), .bit_count(bit_count),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: the current frame is a list of received bits; words are
  // assembled from that list with positional weights once it holds W bits.
  bit          m_bits[$];
  bit          m_order;
  int unsigned m_reg, m_word;
  bit          m_wv, m_ov;

  function automatic void model_reset();
    m_bits.delete();
    m_order = 1'b1;
    m_reg = 0; m_word = 0; m_wv = 0; m_ov = 0;
  endfunction

  function automatic void model_step(bit st, bit lf, bit d, bit dv, bit wr);
    bit          done = 0;
    int unsigned nw = 0;
    if (st) begin
      m_bits.delete();
      m_reg = 0;
      m_ov  = 0;
    end else if (dv) begin
      if (m_bits.size() == 0) m_order = lf;
      m_bits.push_back(d);
      if (m_order) m_reg = (m_reg * 2 + d) % (2 ** W);
      else         m_reg = m_reg / 2 + d * (2 ** (W - 1));
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++)
          nw += m_bits[i] * (m_order ? 2 ** (W - 1 - i) : 2 ** i);
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_wv || wr) begin m_word = nw; m_wv = 1; end
      else m_ov = 1;
    end else if (m_wv && wr) begin
      m_wv = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("word",       32'(word),       m_word);
    check("word_valid", 32'(word_valid), 32'(m_wv));
    check("register",   32'(register),   m_reg);
    check("bit_count",  32'(bit_count),  m_bits.size());
    check("busy",       32'(busy),       32'(m_bits.size() != 0));
    check("overrun",    32'(overrun),    32'(m_ov));
  endtask

  task automatic cyc(input bit st, input bit lf, input bit d, input bit dv, input bit wr);
    start = st; left = lf; din = d; din_valid = dv; word_ready = wr;
    model_step(st, lf, d, dv, wr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Sends one word; word_ready is low except optionally on the final bit.
  task automatic send_word(input logic [W-1:0] v, input bit lf, input int max_gap,
                           input bit wr_last, input bit toggle_left);
    for (int i = 0; i < W; i++) begin
      bit b  = lf ? v[W-1-i] : v[i];
      bit l  = (toggle_left && i > 0) ? 1'($urandom) : lf;
      int g  = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int k = 0; k < g; k++) cyc(0, 1'($urandom), 1'($urandom), 0, 0);
      cyc(0, l, b, 1, (i == W - 1) ? wr_last : 1'b0);
    end
  endtask

  task automatic consume();
    cyc(0, 0, 0, 0, 1);
    check("consume_clears_valid", 32'(word_valid), 32'd0);
  endtask

  typedef struct {
    bit st, lf, d, dv, wr;
    logic [W-1:0] e_reg;
    int e_cnt;
    bit e_busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 1, 1, 0, 16'h0001, 1, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 16'h0001, 1, 1};
    tbl[2] = '{0, 0, 0, 1, 0, 16'h0002, 2, 1};
    tbl[3] = '{0, 0, 1, 1, 0, 16'h0005, 3, 1};
    tbl[4] = '{1, 1, 1, 1, 0, 16'h0000, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 0, 16'h8000, 1, 1};
    tbl[6] = '{0, 1, 1, 1, 0, 16'hC000, 2, 1};
    tbl[7] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0};

    rst_n = 1'b0; start = 0; left = 0; din = 0; din_valid = 0; word_ready = 0;
    model_reset();
    #2;
    check("reset_word",       32'(word),       0);
    check("reset_word_valid", 32'(word_valid), 0);
    check("reset_register",   32'(register),   0);
    check("reset_bit_count",  32'(bit_count),  0);
    check("reset_busy",       32'(busy),       0);
    check("reset_overrun",    32'(overrun),    0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, tbl[i].lf, tbl[i].d, tbl[i].dv, tbl[i].wr);
      check("tbl_register",  32'(register),  32'(tbl[i].e_reg));
      check("tbl_bit_count", 32'(bit_count), tbl[i].e_cnt);
      check("tbl_busy",      32'(busy),      32'(tbl[i].e_busy));
      check("tbl_word_valid", 32'(word_valid), 0);
    end

    // MSB-first back to back
    send_word(16'hA5A5, 1, 0, 0, 0);
    check("msb_word", 32'(word), 32'h0000A5A5);
    check("msb_valid", 32'(word_valid), 1);
    check("msb_count", 32'(bit_count), 0);
    consume();

    // LSB-first with gaps, left toggling mid-frame
    send_word(16'hABCD, 0, 3, 0, 1);
    check("lsb_word", 32'(word), 32'h0000ABCD);
    check("lsb_valid", 32'(word_valid), 1);
    consume();

    // Overrun: second word dropped while the first is pending
    send_word(16'h1234, 1, 0, 0, 0);
    send_word(16'h5678, 1, 0, 0, 0);
    check("ovr_word", 32'(word), 32'h00001234);
    check("ovr_flag", 32'(overrun), 1);
    cyc(1, 0, 0, 0, 0);
    check("ovr_cleared", 32'(overrun), 0);
    check("ovr_word_kept", 32'(word), 32'h00001234);
    check("ovr_valid_kept", 32'(word_valid), 1);
    consume();

    // Completion with word_ready on the same edge: no bubble
    send_word(16'h0F0F, 1, 0, 0, 0);
    send_word(16'hFFFF, 0, 1, 1, 0);
    check("nb_word", 32'(word), 32'h0000FFFF);
    check("nb_valid", 32'(word_valid), 1);
    check("nb_overrun", 32'(overrun), 0);
    consume();

    // Start aborts a partial frame and wins over din_valid
    for (int i = 0; i < 7; i++) cyc(0, 1, 1'($urandom), 1, 0);
    cyc(1, 1, 1, 1, 0);
    check("abort_register", 32'(register), 0);
    check("abort_count", 32'(bit_count), 0);
    check("abort_busy", 32'(busy), 0);
    send_word(16'h00F0, 1, 0, 0, 0);
    check("abort_word", 32'(word), 32'h000000F0);
    consume();

    // Asynchronous reset between edges mid-frame
    for (int i = 0; i < 9; i++) cyc(0, 0, 1'($urandom), 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_register", 32'(register), 0);
    check("areset_count", 32'(bit_count), 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_word", 32'(word), 0);
    check("areset_valid", 32'(word_valid), 0);
    check("areset_overrun", 32'(overrun), 0);
    #1 rst_n = 1'b1;
    send_word(16'hC3C3, 1, 0, 0, 0);
    check("areset_new_word", 32'(word), 32'h0000C3C3);
    consume();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(39) == 0), 1'($urandom), 1'($urandom),
          ($urandom_range(9) < 7), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
